// File: rtl/msx_input_pkg.sv
// Shared definitions for the MSX joystick/mouse port logic: joystick bit map,
// mouse nibble sequence and the 8-bit clip used when snapshotting motion.
package msx_input_pkg;

   localparam int JOY_UP = 0;
   localparam int JOY_DN = 1;
   localparam int JOY_LT = 2;
   localparam int JOY_RT = 3;
   localparam int JOY_B1 = 4;
   localparam int JOY_B2 = 5;

   typedef enum logic [1:0] {MS_XH, MS_XL, MS_YH, MS_YL} mouse_nib_t;

   // Clip a sign-extended accumulator to the 8-bit signed range the MSX reads.
   function automatic logic signed [7:0] sat8(input logic signed [31:0] v);
      if (v > 32'sd127) return 8'h7F;
      if (v < -32'sd128) return 8'h80;
      return v[7:0];
   endfunction

endpackage

// File: rtl/msx_pointer_port_if.sv
// Port bundle between the MiST input streams (user_io side) and the MSX
// joystick ports; port p occupies element [p] of the packed arrays.
interface msx_pointer_port_if #(
   parameter int NPORTS = 2
);
   logic [NPORTS-1:0][5:0] joy_i;
   logic signed [8:0]      mouse_x;
   logic signed [8:0]      mouse_y;
   logic [1:0]             mouse_flags;
   logic                   mouse_strobe;
   logic [1:0]             mouse_sel;
   logic [NPORTS-1:0]      str_i;
   logic [NPORTS-1:0][5:0] port_o;
   logic [NPORTS-1:0]      mouse_act;

   modport master (
      output joy_i, mouse_x, mouse_y, mouse_flags, mouse_strobe, mouse_sel, str_i,
      input  port_o, mouse_act
   );

   modport slave (
      input  joy_i, mouse_x, mouse_y, mouse_flags, mouse_strobe, mouse_sel, str_i,
      output port_o, mouse_act
   );
endinterface

// File: rtl/msx_mouse_nibble_fsm.sv
// Per-port MSX mouse engine: strobe edge detect, 4-nibble sequencer, read
// timeout, and saturating X/Y motion accumulators with the read snapshot.
module msx_mouse_nibble_fsm
   import msx_input_pkg::*;
#(
   parameter int TIMEOUT_CYC = 100000,
   parameter int ACC_W       = 10
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       act,
   input  logic       str,
   input  logic       strobe,
   input  logic [8:0] mx,
   input  logic [8:0] my,
   output logic [3:0] nib_d
);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int WW = ACC_W + 3;
   localparam logic signed [WW-1:0] AMAX = WW'((1 << (ACC_W - 1)) - 1);
   localparam logic signed [WW-1:0] AMIN = -AMAX;

   mouse_nib_t              st_q, st_d;
   logic                    str_q, edge_w;
   logic [TW-1:0]           tmo_q, tmo_d;
   logic signed [7:0]       sx_q, sx_d, sy_q, sy_d;
   logic signed [ACC_W-1:0] ax_q, ax_d, ay_q, ay_d;
   logic [3:0]              nib_q;
   logic signed [WW-1:0]    sub_x, sub_y, dlt_x, dlt_y;

   function automatic logic signed [WW-1:0] ext_a(input logic [ACC_W-1:0] a);
      return {{(WW-ACC_W){a[ACC_W-1]}}, a};
   endfunction

   function automatic logic signed [WW-1:0] ext_8(input logic [7:0] s);
      return {{(WW-8){s[7]}}, s};
   endfunction

   function automatic logic signed [WW-1:0] ext_9(input logic [8:0] m);
      return {{(WW-9){m[8]}}, m};
   endfunction

   function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [WW-1:0] v);
      if (v > AMAX) return AMAX[ACC_W-1:0];
      if (v < AMIN) return AMIN[ACC_W-1:0];
      return v[ACC_W-1:0];
   endfunction

   assign edge_w = str ^ str_q;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         st_q  <= MS_XH;
         str_q <= 1'b0;
         tmo_q <= '0;
         sx_q  <= '0;
         sy_q  <= '0;
         ax_q  <= '0;
         ay_q  <= '0;
         nib_q <= '0;
      end else begin
         st_q  <= st_d;
         str_q <= str;
         tmo_q <= tmo_d;
         sx_q  <= sx_d;
         sy_q  <= sy_d;
         ax_q  <= ax_d;
         ay_q  <= ay_d;
         nib_q <= nib_d;
      end
   end

   always_comb begin
      st_d  = st_q;
      tmo_d = tmo_q;
      sx_d  = sx_q;
      sy_d  = sy_q;
      nib_d = nib_q;
      sub_x = '0;
      sub_y = '0;
      if (edge_w) begin
         tmo_d = TW'(TIMEOUT_CYC);
         case (st_q)
            MS_XH: begin
               // Snapshot uses the pre-strobe accumulator; a same-cycle delta lands after it.
               sx_d  = sat8({{(32-ACC_W){ax_q[ACC_W-1]}}, ax_q});
               sy_d  = sat8({{(32-ACC_W){ay_q[ACC_W-1]}}, ay_q});
               sub_x = ext_8(sx_d);
               sub_y = ext_8(sy_d);
               nib_d = sx_d[7:4];
               st_d  = MS_XL;
            end
            MS_XL: begin nib_d = sx_q[3:0]; st_d = MS_YH; end
            MS_YH: begin nib_d = sy_q[7:4]; st_d = MS_YL; end
            MS_YL: begin nib_d = sy_q[3:0]; st_d = MS_XH; end
         endcase
      end else if (tmo_q != '0) begin
         tmo_d = tmo_q - TW'(1);
         if (tmo_q == TW'(1)) st_d = MS_XH;
      end
      // MiST X grows rightwards; the MSX protocol expects the opposite sign.
      dlt_x = (act && strobe) ? -ext_9(mx) : '0;
      dlt_y = (act && strobe) ? ext_9(my) : '0;
      ax_d  = sat_acc(ext_a(ax_q) - sub_x + dlt_x);
      ay_d  = sat_acc(ext_a(ay_q) - sub_y + dlt_y);
      if (!act) begin
         st_d  = MS_XH;
         tmo_d = '0;
         sx_d  = '0;
         sy_d  = '0;
         ax_d  = '0;
         ay_d  = '0;
         nib_d = '0;
      end
   end

endmodule

// File: rtl/msx_pointer_port.sv
// MSX general-purpose port driver: per-port joystick/mouse mode select and
// registered pin levels (1 = released, 0 = driven low).
module msx_pointer_port
   import msx_input_pkg::*;
#(
   parameter int NPORTS      = 2,
   parameter int TIMEOUT_CYC = 100000,
   parameter int ACC_W       = 10
) (
   input logic               clk_sys,
   input logic               reset,
   msx_pointer_port_if.slave bus
);
   logic [NPORTS-1:0][5:0] port_all;
   logic [NPORTS-1:0]      act_all;

   for (genvar p = 0; p < NPORTS; p++) begin : g_port
      logic       hit, act_q, act_d;
      logic [5:0] joy_o, port_q;
      logic [3:0] nib;

      assign hit   = bus.mouse_strobe && (bus.mouse_sel == 2'(p));
      // Any joystick activity on the port drops it out of mouse mode, even against a set.
      assign act_d = (act_q || hit) && (bus.joy_i[p] == 6'd0);
      assign joy_o = ~(bus.joy_i[p] & {6{~bus.str_i[p]}});

      always_ff @(posedge clk_sys) begin
         if (reset) begin
            act_q  <= 1'b0;
            port_q <= '1;
         end else begin
            act_q  <= act_d;
            port_q <= act_d ? {~bus.mouse_flags, nib} : joy_o;
         end
      end

      msx_mouse_nibble_fsm #(
         .TIMEOUT_CYC (TIMEOUT_CYC),
         .ACC_W       (ACC_W)
      ) u_fsm (
         .clk_sys (clk_sys),
         .reset   (reset),
         .act     (act_q),
         .str     (bus.str_i[p]),
         .strobe  (hit),
         .mx      (bus.mouse_x),
         .my      (bus.mouse_y),
         .nib_d   (nib)
      );

      assign port_all[p] = port_q;
      assign act_all[p]  = act_q;
   end

   assign bus.port_o    = port_all;
   assign bus.mouse_act = act_all;

endmodule
